hazard_scoreboard: RTL

Destination-tracking pipeline that produces the per-stage write-back tags (Rd, RegWrite) the forwarding logic compares against, and detects load-use hazards between the ID-stage instruction and the instruction in EX. It holds a three-entry shift pipe (EX, MEM, WB) of destination records. It emits a stall request on load-use or memory wait, inserts bubbles, and honours branch flushes. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers in the five-stage RISC-V core.

---
 rtl/hazard_scoreboard_pkg.sv | 16 +
 rtl/hazard_scoreboard_stage_entry_reg.sv | 30 +++
 rtl/hazard_scoreboard.sv | 100 ++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the destination-tracking pipe: register index width,
// the per-stage destination record and the bubble constant.
package hazard_scoreboard_pkg;

    localparam int REG_W = 5;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } entry_t;

    localparam entry_t BUBBLE = '0;

endpackage

// File: rtl/hazard_scoreboard_stage_entry_reg.sv
// One destination record register; hold beats clear, clear beats load.
// Single-cycle load, no internal backpressure (hold is the freeze input).
module stage_entry_reg
    import hazard_scoreboard_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_hold,
    input  logic   i_clear,
    input  entry_t i_d,
    output entry_t o_q
);

    entry_t r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= BUBBLE;
        end else if (!i_hold) begin
            if (i_clear) begin
                r_q <= BUBBLE;
            end else begin
                r_q <= i_d;
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// EX/MEM/WB destination tags for forwarding plus load-use stall detection.
// Stall_o is combinational; memory wait freezes all three stages.
module hazard_scoreboard #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ID_Valid_i,
    input  logic [REG_W-1:0] ID_Rs1_i,
    input  logic [REG_W-1:0] ID_Rs2_i,
    input  logic [REG_W-1:0] ID_Rd_i,
    input  logic             ID_RegWrite_i,
    input  logic             ID_MemRead_i,
    input  logic             Flush_i,
    input  logic             Mem_Ready_i,
    output logic             Stall_o,
    output logic [REG_W-1:0] EX_Rd_o,
    output logic [REG_W-1:0] MEM_Rd_o,
    output logic [REG_W-1:0] WB_Rd_o,
    output logic             EX_RegWrite_o,
    output logic             MEM_RegWrite_o,
    output logic             WB_RegWrite_o,
    output logic [CNT_W-1:0] Stall_Count_o
);

    import hazard_scoreboard_pkg::*;

    entry_t           w_id_rec;
    entry_t           w_ex;
    entry_t           w_mem;
    entry_t           w_wb;
    logic             w_lu;
    logic             w_freeze;
    logic             w_ex_clear;
    logic [CNT_W-1:0] r_cnt;

    // A non-valid ID slot enters EX as a plain bubble; x0 never shows as a write.
    always_comb begin
        w_id_rec = BUBBLE;
        if (ID_Valid_i) begin
            w_id_rec.valid    = 1'b1;
            w_id_rec.rd       = ID_Rd_i;
            w_id_rec.regwrite = ID_RegWrite_i & (ID_Rd_i != '0);
            w_id_rec.memread  = ID_MemRead_i;
        end
    end

    assign w_lu = w_ex.valid & w_ex.memread & (w_ex.rd != '0) & ID_Valid_i &
                  ((w_ex.rd == ID_Rs1_i) | (w_ex.rd == ID_Rs2_i));

    assign w_freeze   = ~Mem_Ready_i;
    assign w_ex_clear = Flush_i | w_lu;
    assign Stall_o    = w_freeze | (w_lu & ~Flush_i);

    stage_entry_reg u_ex (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_hold  (w_freeze),
        .i_clear (w_ex_clear),
        .i_d     (w_id_rec),
        .o_q     (w_ex)
    );

    stage_entry_reg u_mem (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_hold  (w_freeze),
        .i_clear (1'b0),
        .i_d     (w_ex),
        .o_q     (w_mem)
    );

    stage_entry_reg u_wb (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_hold  (w_freeze),
        .i_clear (1'b0),
        .i_d     (w_mem),
        .o_q     (w_wb)
    );

    // Only bubbles actually inserted by load-use are counted; flush wins over lu.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (Mem_Ready_i && !Flush_i && w_lu && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign EX_Rd_o        = w_ex.rd;
    assign MEM_Rd_o       = w_mem.rd;
    assign WB_Rd_o        = w_wb.rd;
    assign EX_RegWrite_o  = w_ex.valid & w_ex.regwrite;
    assign MEM_RegWrite_o = w_mem.valid & w_mem.regwrite;
    assign WB_RegWrite_o  = w_wb.valid & w_wb.regwrite;
    assign Stall_Count_o  = r_cnt;

endmodule
